// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: 32-step shift-add multiply / restoring divide,
// sign fixup, HI/LO commit, and the pipeline stall for HI/LO hazards.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hilo_rd,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  step;
  logic        is_div;
  logic        neg_q;
  logic        neg_r;
  logic        div0;
  logic [31:0] a_orig;
  logic [31:0] opnd;
  logic [64:0] acc;

  logic        sa, sb;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum, rem_sh, diff;
  logic [64:0] acc_next;
  logic [63:0] prod;
  logic [31:0] fix_hi, fix_lo;

  // Signed ops are op[0]==0 (MULT, DIV); only they take magnitudes.
  always_comb begin
    sa    = ~op[0] & a[31];
    sb    = ~op[0] & b[31];
    mag_a = sa ? (32'd0 - a) : a;
    mag_b = sb ? (32'd0 - b) : b;
  end

  // Multiply keeps {upper(33), multiplier(32)} in acc; divide keeps {rem, quot} in acc[63:0].
  always_comb begin
    mul_sum  = acc[64:32] + {1'b0, opnd};
    rem_sh   = acc[63:31];
    diff     = rem_sh - {1'b0, opnd};
    acc_next = acc >> 1;
    if (is_div) begin
      acc_next = {1'b0, (diff[32] ? rem_sh[31:0] : diff[31:0]), acc[30:0], ~diff[32]};
    end else if (acc[0]) begin
      acc_next = {mul_sum, acc[31:0]} >> 1;
    end
  end

  always_comb begin
    prod   = neg_q ? (64'd0 - acc[63:0]) : acc[63:0];
    fix_hi = prod[63:32];
    fix_lo = prod[31:0];
    if (is_div) begin
      if (div0) begin
        fix_hi = a_orig;
        fix_lo = '1;
      end else begin
        fix_hi = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
        fix_lo = neg_q ? (32'd0 - acc[31:0])  : acc[31:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      step   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      a_orig <= '0;
      opnd   <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi_we) hi <= wdata;
          if (mtlo_we) lo <= wdata;
          if (start) begin
            is_div <= op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            div0   <= op[1] & (b == 32'd0);
            a_orig <= a;
            opnd   <= op[1] ? mag_b : mag_a;
            acc    <= {33'd0, (op[1] ? mag_a : mag_b)};
            step   <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc  <= acc_next;
            step <= step + 6'd1;
            if (step == 6'd31) state <= FIX;
          end
        end
        FIX: begin
          if (!flush) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign stall = busy & (start | hilo_rd | mthi_we | mtlo_we);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        hilo_rd;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] wdata;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hilo_rd(hilo_rd), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
    .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {hi, lo} as the architecture defines them.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: res = sx * sy;
      2'b01: res = {32'd0, x} * {32'd0, y};
      default: begin
        if (y == 32'd0) begin
          res = {x, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {x % y, x / y};
        end
      end
    endcase
    return res;
  endfunction

  task automatic write_hilo(input logic hw, input logic lw, input logic [31:0] d);
    @(negedge clk);
    mthi_we = hw; mtlo_we = lw; wdata = d;
    @(posedge clk); #1;
    if (hw) hi_m = d;
    if (lw) lo_m = d;
    check("mt_hi", hi, hi_m);
    check("mt_lo", lo, lo_m);
    @(negedge clk);
    mthi_we = 1'b0; mtlo_we = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit haz, input bit wr, input bit fl);
    logic [63:0] e;
    logic [31:0] wd;
    e  = model(o, x, y);
    wd = $urandom;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    mthi_we = wr; mtlo_we = wr; wdata = wd; flush = fl;
    #1 check("stall_idle", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    if (wr) begin
      hi_m = wd;
      lo_m = wd;
    end
    check("busy_accept", {31'd0, busy}, 32'd1);
    check("hi_accept", hi, hi_m);
    check("lo_accept", lo, lo_m);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      start = haz; hilo_rd = haz; mthi_we = haz; mtlo_we = 1'b0; flush = 1'b0;
      wdata = $urandom;
      #1 check("stall_busy", {31'd0, stall}, {31'd0, haz});
      @(posedge clk); #1;
      if (k < 33) begin
        check("busy_run", {31'd0, busy}, 32'd1);
        check("done_run", {31'd0, done}, 32'd0);
        if (k == 16) check("hi_hold", hi, hi_m);
      end else begin
        hi_m = e[63:32];
        lo_m = e[31:0];
        check("hi_commit", hi, hi_m);
        check("lo_commit", lo, lo_m);
        check("done_commit", {31'd0, done}, 32'd1);
        check("busy_commit", {31'd0, busy}, 32'd0);
      end
    end
    @(negedge clk);
    start = 1'b0; mthi_we = 1'b0;
    #1 check("stall_after", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check("done_pulse", {31'd0, done}, 32'd0);
    hilo_rd = 1'b0;
  endtask

  task automatic run_flush(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input int n);
    int dones;
    dones = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    check("busy_fl_accept", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < n; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    check("busy_flush", {31'd0, busy}, 32'd0);
    check("hi_flush", hi, hi_m);
    check("lo_flush", lo, lo_m);
    @(negedge clk);
    flush = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("no_done_flush", dones, 32'd0);
    check("hi_flush_late", hi, hi_m);
  endtask

  task automatic run_reset(input int n);
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    hi_m = '0;
    lo_m = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    int sel;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    hilo_rd = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;
    #12;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
    run_op(2'b11, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

    write_hilo(1'b1, 1'b0, 32'h11);
    write_hilo(1'b0, 1'b1, 32'h22);
    run_op(2'b11, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0);
    check("hazard_hi", hi, 32'd2);
    check("hazard_lo", lo, 32'd14);
    write_hilo(1'b1, 1'b1, 32'hA5A5_0F0F);

    run_flush(2'b00, 32'd1234, 32'd5678, 10);
    run_op(2'b01, 32'd3, 32'd9, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ro  = 2'($urandom_range(0, 3));
      rx  = $urandom;
      ry  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) ry = '0;
      else if (sel == 1) begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
      else if (sel == 2) ry = 32'($urandom_range(1, 15));
      else if (sel == 3) ry = 32'd0 - 32'($urandom_range(1, 15));
      run_op(ro, rx, ry, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 5) == 0));
    end

    run_flush(2'b10, $urandom, 32'd3, 33);
    run_reset(15);
    run_op(2'b00, $urandom, $urandom, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
